// File: rtl/ex_muldiv_unit_pkg.sv
// Shared types and constants for the execute-stage multiply/divide unit.
package ex_muldiv_unit_pkg;

    localparam int unsigned XLEN              = 32;
    localparam int unsigned MULDIV_DIV_CYCLES = XLEN;
    localparam int unsigned CNT_W             = $clog2(MULDIV_DIV_CYCLES);

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } muldiv_state_e;

    typedef struct packed {
        muldiv_op_e      op;
        logic [XLEN-1:0] rs1;
        logic [XLEN-1:0] rs2;
    } muldiv_req_t;

    // Two's-complement negate when neg is set.
    function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic neg);
        return neg ? (~v + XLEN'(1)) : v;
    endfunction

endpackage

// File: rtl/ex_muldiv_unit_serial_divider.sv
// Unsigned radix-2 restoring divider; one quotient bit per cycle for XLEN cycles.
module serial_divider
    import ex_muldiv_unit_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            abort,
    input  logic            start,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] quotient_c,
    output logic [XLEN-1:0] remainder_c,
    output logic            valid_c
);

    logic [XLEN-1:0]  quo_q;
    logic [XLEN-1:0]  rem_q;
    logic [XLEN-1:0]  dvs_q;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;

    logic [XLEN:0]    shifted;
    logic [XLEN:0]    diff;
    logic             ge;
    logic [XLEN-1:0]  quo_step;
    logic [XLEN-1:0]  rem_step;

    // Current restoring step; exposed so the caller can use the final step directly.
    always_comb begin
        shifted  = {rem_q, quo_q[XLEN-1]};
        diff     = shifted - {1'b0, dvs_q};
        ge       = ~diff[XLEN];
        rem_step = ge ? diff[XLEN-1:0] : shifted[XLEN-1:0];
        quo_step = {quo_q[XLEN-2:0], ge};
    end

    assign quotient_c  = quo_step;
    assign remainder_c = rem_step;
    assign valid_c     = busy_q && (cnt_q == CNT_W'(MULDIV_DIV_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            quo_q  <= '0;
            rem_q  <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else if (abort) begin
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else if (start) begin
            quo_q  <= dividend;
            rem_q  <= '0;
            dvs_q  <= divisor;
            cnt_q  <= '0;
            busy_q <= 1'b1;
        end else if (busy_q) begin
            quo_q  <= quo_step;
            rem_q  <= rem_step;
            cnt_q  <= valid_c ? '0 : cnt_q + CNT_W'(1);
            busy_q <= ~valid_c;
        end
    end

endmodule

// File: rtl/ex_muldiv_unit.sv
// RV32 M-extension execute unit: 2-cycle multiplier, iterative divider, pipeline stall.
module ex_muldiv_unit
    import ex_muldiv_unit_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush_i,
    input  logic            start_i,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    output logic            stall_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    muldiv_state_e   state_q, state_n;
    muldiv_req_t     req_q, req_in;
    logic [XLEN-1:0] result_n;
    logic            done_n;
    logic            capture;
    logic            div_start;

    logic            in_signed, in_rem, in_div0, in_ovf;
    logic [XLEN-1:0] special_res;
    logic [XLEN-1:0] dvd_abs, dvs_abs;

    logic            a_s, b_s;
    logic [2*XLEN-1:0] a_w, b_w, prod;
    logic [XLEN-1:0] mul_res;

    logic [XLEN-1:0] quo_c, rem_c;
    logic            div_valid_c;
    logic            q_neg, r_neg;
    logic [XLEN-1:0] div_res;

    // Decode of the incoming instruction: special cases and divider magnitudes.
    always_comb begin
        req_in      = '{op: muldiv_op_e'(op_i), rs1: rs1_i, rs2: rs2_i};
        in_signed   = ~op_i[0];
        in_rem      = op_i[1];
        in_div0     = (rs2_i == '0);
        in_ovf      = in_signed && (rs1_i == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_i == '1);
        if (in_div0)
            special_res = in_rem ? rs1_i : '1;
        else
            special_res = in_rem ? '0 : rs1_i;
        dvd_abs     = cond_neg(rs1_i, in_signed & rs1_i[XLEN-1]);
        dvs_abs     = cond_neg(rs2_i, in_signed & rs2_i[XLEN-1]);
    end

    // Multiplier on captured operands; 2*XLEN extension keeps every signedness mix exact.
    always_comb begin
        a_s     = ((req_q.op == OP_MULH) || (req_q.op == OP_MULHSU)) & req_q.rs1[XLEN-1];
        b_s     = (req_q.op == OP_MULH) & req_q.rs2[XLEN-1];
        a_w     = {{XLEN{a_s}}, req_q.rs1};
        b_w     = {{XLEN{b_s}}, req_q.rs2};
        prod    = a_w * b_w;
        mul_res = (req_q.op == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end

    serial_divider u_div (
        .clk         (clk),
        .rst_n       (rst_n),
        .abort       (flush_i),
        .start       (div_start),
        .dividend    (dvd_abs),
        .divisor     (dvs_abs),
        .quotient_c  (quo_c),
        .remainder_c (rem_c),
        .valid_c     (div_valid_c)
    );

    // Sign fix: quotient negative iff signs differ, remainder follows the dividend.
    always_comb begin
        q_neg   = ~req_q.op[0] & (req_q.rs1[XLEN-1] ^ req_q.rs2[XLEN-1]);
        r_neg   = ~req_q.op[0] & req_q.rs1[XLEN-1];
        div_res = req_q.op[1] ? cond_neg(rem_c, r_neg) : cond_neg(quo_c, q_neg);
    end

    always_comb begin
        state_n   = state_q;
        result_n  = result_o;
        done_n    = 1'b0;
        capture   = 1'b0;
        div_start = 1'b0;
        stall_o   = 1'b0;
        if (flush_i) begin
            state_n = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        stall_o = 1'b1;
                        capture = 1'b1;
                        if (!op_i[2]) begin
                            state_n = MUL;
                        end else if (in_div0 || in_ovf) begin
                            state_n  = DONE;
                            result_n = special_res;
                            done_n   = 1'b1;
                        end else begin
                            state_n   = DIV;
                            div_start = 1'b1;
                        end
                    end
                end
                MUL: begin
                    stall_o  = 1'b1;
                    result_n = mul_res;
                    done_n   = 1'b1;
                    state_n  = DONE;
                end
                DIV: begin
                    stall_o = 1'b1;
                    if (div_valid_c) begin
                        result_n = div_res;
                        done_n   = 1'b1;
                        state_n  = DONE;
                    end
                end
                DONE: state_n = IDLE;
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            req_q    <= '0;
            result_o <= '0;
            done_o   <= 1'b0;
        end else begin
            state_q  <= state_n;
            result_o <= result_n;
            done_o   <= done_n;
            if (capture)
                req_q <= req_in;
        end
    end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit against an arithmetic reference model.
module tb_ex_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush_i;
    logic        start_i;
    logic [2:0]  op_i;
    logic [31:0] rs1_i;
    logic [31:0] rs2_i;
    logic        stall_o;
    logic        done_o;
    logic [31:0] result_o;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] last_exp = '0;

    ex_muldiv_unit dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush_i  (flush_i),
        .start_i  (start_i),
        .op_i     (op_i),
        .rs1_i    (rs1_i),
        .rs2_i    (rs2_i),
        .stall_o  (stall_o),
        .done_o   (done_o),
        .result_o (result_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] model_res(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int          sa = a;
        int          sb = b;
        longint      sp;
        logic [63:0] t;
        logic        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            3'd0: return a * b;
            3'd1: begin sp = longint'(sa) * longint'(sb); t = sp; return t[63:32]; end
            3'd2: begin sp = longint'(sa) * longint'({32'b0, b}); t = sp; return t[63:32]; end
            3'd3: begin t = {32'b0, a} * {32'b0, b}; return t[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return 32'h8000_0000;
                return sa / sb;
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return 32'h0;
                return sa % sb;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int model_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op < 3'd4) return 2;
        if (b == 0) return 1;
        if (op[0] == 1'b0 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    // Start an op in the next cycle and wait (bounded) for done_o; lat=-1 on timeout.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit scramble, output logic [31:0] res, output int lat,
                         output int stalls, output logic stall_at_done);
        @(posedge clk); #1;
        start_i = 1'b1; op_i = op; rs1_i = a; rs2_i = b;
        lat = -1; stalls = 0; res = '0; stall_at_done = 1'b1;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (done_o) begin
                lat = k; res = result_o; stall_at_done = stall_o;
                break;
            end
            if (stall_o) stalls++;
            @(posedge clk); #1;
            if (scramble) begin rs1_i = $urandom; rs2_i = $urandom; end
        end
    endtask

    task automatic go_idle();
        @(posedge clk); #1;
        start_i = 1'b0;
    endtask

    task automatic check_op(input string name, input logic [2:0] op, input logic [31:0] a,
                            input logic [31:0] b, input bit scramble, input bit check_stall);
        logic [31:0] res, exp;
        int          lat, stalls, elat;
        logic        sad;
        exp  = model_res(op, a, b);
        elat = model_lat(op, a, b);
        issue(op, a, b, scramble, res, lat, stalls, sad);
        total++;
        if (lat !== elat) begin
            bad++; $display("FAIL %s latency: got %0d want %0d", name, lat, elat);
        end
        total++;
        if (res !== exp) begin
            bad++; $display("FAIL %s result: got %h want %h (op=%0d a=%h b=%h)", name, res, exp, op, a, b);
        end
        if (check_stall) begin
            total++;
            if (stalls !== elat) begin
                bad++; $display("FAIL %s stall cycles: got %0d want %0d", name, stalls, elat);
            end
            total++;
            if (sad !== 1'b0) begin
                bad++; $display("FAIL %s stall in done cycle: got %b want 0", name, sad);
            end
        end
        last_exp = exp;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush_i = 1'b0; start_i = 1'b0; op_i = '0; rs1_i = '0; rs2_i = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (result_o !== 32'h0) begin bad++; $display("FAIL reset result: got %h want 0", result_o); end
        total++;
        if (done_o !== 1'b0) begin bad++; $display("FAIL reset done: got %b want 0", done_o); end
        total++;
        if (stall_o !== 1'b0) begin bad++; $display("FAIL reset stall: got %b want 0", stall_o); end
        last_exp = '0;
    endtask

    task automatic test_mul();
        check_op("mul_7x-3", 3'd0, 32'h7, 32'hFFFF_FFFD, 1'b1, 1'b1);
        go_idle();
        check_op("mulh_m1", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1);
        go_idle();
        check_op("mulhsu_m1", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1);
        go_idle();
        check_op("mulhu_m1", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1);
        go_idle();
    endtask

    task automatic test_div();
        check_op("div_-20/3", 3'd4, 32'hFFFF_FFEC, 32'h3, 1'b1, 1'b1);
        go_idle();
        check_op("rem_-20/3", 3'd6, 32'hFFFF_FFEC, 32'h3, 1'b1, 1'b1);
        go_idle();
    endtask

    task automatic test_special();
        check_op("divu_5/0", 3'd5, 32'h5, 32'h0, 1'b0, 1'b1);
        go_idle();
        check_op("remu_5/0", 3'd7, 32'h5, 32'h0, 1'b0, 1'b1);
        go_idle();
        check_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1);
        go_idle();
        check_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1);
        go_idle();
    endtask

    task automatic test_flush();
        int seen_done = 0;
        @(posedge clk); #1;
        start_i = 1'b1; op_i = 3'd5; rs1_i = 32'd100; rs2_i = 32'd7;
        repeat (10) @(posedge clk);
        #1 flush_i = 1'b1; start_i = 1'b0;
        @(negedge clk);
        total++;
        if (stall_o !== 1'b0) begin bad++; $display("FAIL flush stall: got %b want 0", stall_o); end
        @(posedge clk); #1 flush_i = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done_o) seen_done++;
        end
        total++;
        if (seen_done !== 0) begin bad++; $display("FAIL flush done pulses: got %0d want 0", seen_done); end
        total++;
        if (result_o !== last_exp) begin bad++; $display("FAIL flush result held: got %h want %h", result_o, last_exp); end
        check_op("divu_100/7", 3'd5, 32'd100, 32'd7, 1'b1, 1'b1);
        go_idle();
        // flush together with start in IDLE must not start anything
        @(posedge clk); #1 start_i = 1'b1; flush_i = 1'b1; op_i = 3'd0;
        @(negedge clk);
        total++;
        if (stall_o !== 1'b0) begin bad++; $display("FAIL flush_start stall: got %b want 0", stall_o); end
        @(posedge clk); #1 start_i = 1'b0; flush_i = 1'b0;
        @(negedge clk);
        total++;
        if (stall_o !== 1'b0 || done_o !== 1'b0) begin
            bad++; $display("FAIL flush_start aftermath: got stall=%b done=%b want 0 0", stall_o, done_o);
        end
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1;
        start_i = 1'b1; op_i = 3'd4; rs1_i = 32'h1234_5678; rs2_i = 32'h13;
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0; start_i = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (result_o !== 32'h0) begin bad++; $display("FAIL midreset result: got %h want 0", result_o); end
        total++;
        if (done_o !== 1'b0) begin bad++; $display("FAIL midreset done: got %b want 0", done_o); end
        total++;
        if (stall_o !== 1'b0) begin bad++; $display("FAIL midreset stall: got %b want 0", stall_o); end
        last_exp = '0;
    endtask

    task automatic test_back_to_back();
        check_op("b2b_mul", 3'd0, $urandom, $urandom, 1'b1, 1'b1);
        check_op("b2b_divu", 3'd5, $urandom, 32'h0001_0000 | 32'($urandom_range(1, 1000)), 1'b1, 1'b1);
        check_op("b2b_mulh", 3'd1, $urandom, $urandom, 1'b0, 1'b1);
        go_idle();
    endtask

    task automatic test_random();
        logic [2:0]  op;
        logic [31:0] a, b;
        for (int i = 0; i < 50; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 6))
                0: b = 32'h0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(1, 15));
                3: begin a = 32'($urandom_range(0, 50)); b = 32'hFFFF_FFFF - 32'($urandom_range(0, 5)); end
                default: ;
            endcase
            check_op("random", op, a, b, 1'($urandom_range(0, 1)), 1'b0);
            if ($urandom_range(0, 1) == 1) go_idle();
        end
        go_idle();
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_special();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        test_random();
        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
